// File: rtl/downsample_div_seq_pkg.sv
// Shared types and constants for the DownSample sequential divider.
// The optional rounding stage is enabled with DOWNSAMPLE_DIV_ROUND_EN.
package downsample_div_pkg;

  localparam int DIVIDEND_W_DEF = 10;
  localparam int DIVISOR_W_DEF  = 6;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CALC  = 2'd1,
    ROUND = 2'd2,
    DONE  = 2'd3
  } state_e;

  // Width of a counter that can hold 0..dividend_w.
  function automatic int cnt_w(input int dividend_w);
    return $clog2(dividend_w + 1);
  endfunction

endpackage

// File: rtl/downsample_div_seq_if.sv
// Block-level ap_* handshake plus operand/result bus of the sequential divider.
interface downsample_div_seq_if
  import downsample_div_pkg::*;
#(
  parameter int DIVIDEND_W = DIVIDEND_W_DEF,
  parameter int DIVISOR_W  = DIVISOR_W_DEF
);

  logic                        ap_start;
  logic                        ap_ready;
  logic                        ap_idle;
  logic                        ap_done;
  logic signed [DIVIDEND_W-1:0] din0;
  logic        [DIVISOR_W-1:0]  din1;
  logic signed [DIVIDEND_W-1:0] quot;
  logic signed [DIVISOR_W:0]    rem;
  logic                        div_zero;

  modport master (
    output ap_start, din0, din1,
    input  ap_ready, ap_idle, ap_done, quot, rem, div_zero
  );

  modport slave (
    input  ap_start, din0, din1,
    output ap_ready, ap_idle, ap_done, quot, rem, div_zero
  );

endinterface

// File: rtl/downsample_div_seq_step.sv
// One combinational restoring-division step: shift in a dividend bit, trial-subtract.
module downsample_div_step #(
  parameter int DIVISOR_W = 6
) (
  input  logic [DIVISOR_W:0]   prem_i,
  input  logic                 bit_i,
  input  logic [DIVISOR_W-1:0] dvsr_i,
  output logic [DIVISOR_W:0]   prem_o,
  output logic                 qbit_o
);

  logic [DIVISOR_W+1:0] trial;
  logic [DIVISOR_W:0]   diff;

  assign trial  = {prem_i, bit_i};
  assign qbit_o = (trial >= {2'b00, dvsr_i});
  // When the subtraction is taken the result is below the divisor, so the low bits suffice.
  assign diff   = trial[DIVISOR_W:0] - {1'b0, dvsr_i};
  assign prem_o = qbit_o ? diff : trial[DIVISOR_W:0];

endmodule

// File: rtl/downsample_div_seq.sv
// Sequential signed-by-unsigned restoring divider with ap_* handshake.
// Define DOWNSAMPLE_DIV_ROUND_EN for round-half-away-from-zero via an extra ROUND cycle.
module downsample_div_seq
  import downsample_div_pkg::*;
#(
  parameter int DIVIDEND_W = DIVIDEND_W_DEF,
  parameter int DIVISOR_W  = DIVISOR_W_DEF
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst_n,
  downsample_div_seq_if.slave   bus
);

  localparam int CNT_W = cnt_w(DIVIDEND_W);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(DIVIDEND_W - 1);

  localparam logic [1:0] ST_IDLE  = 2'(IDLE);
  localparam logic [1:0] ST_CALC  = 2'(CALC);
  localparam logic [1:0] ST_ROUND = 2'(ROUND);
  localparam logic [1:0] ST_DONE  = 2'(DONE);

  logic [1:0]                   state_q, state_d;
  logic [CNT_W-1:0]             cnt_q, cnt_d;
  logic                         done_q, idle_q;
  logic signed [DIVIDEND_W-1:0] quot_q;
  logic signed [DIVISOR_W:0]    rem_q;
  logic                         div_zero_q;

  // Magnitude register doubles as the quotient shift register (quotient bits enter at the LSB).
  logic [DIVIDEND_W-1:0]        dvd_q, dvd_d;
  logic [DIVISOR_W:0]           prem_q, prem_d;
  logic [DIVISOR_W-1:0]         dvsr_q, dvsr_d;
  logic                         neg_q, neg_d;
  logic                         dz_q, dz_d;

  logic [DIVIDEND_W-1:0]        abs_din0;
  logic [DIVISOR_W:0]           step_prem;
  logic                         step_qbit;
  logic signed [DIVIDEND_W-1:0] quot_res;
  logic signed [DIVISOR_W:0]    rem_res;

  // Unsigned view of the negated value is exact even for the most negative input.
  assign abs_din0 = bus.din0[DIVIDEND_W-1] ? -bus.din0 : bus.din0;

  downsample_div_step #(
    .DIVISOR_W (DIVISOR_W)
  ) u_step (
    .prem_i (prem_q),
    .bit_i  (dvd_q[DIVIDEND_W-1]),
    .dvsr_i (dvsr_q),
    .prem_o (step_prem),
    .qbit_o (step_qbit)
  );

`ifdef DOWNSAMPLE_DIV_ROUND_EN
  logic round_up;
  assign round_up = ({prem_q, 1'b0} >= {2'b00, dvsr_q});
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dvd_d   = dvd_q;
    prem_d  = prem_q;
    dvsr_d  = dvsr_q;
    neg_d   = neg_q;
    dz_d    = dz_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.ap_start) begin
          dvd_d   = abs_din0;
          prem_d  = '0;
          dvsr_d  = bus.din1;
          neg_d   = bus.din0[DIVIDEND_W-1];
          dz_d    = (bus.din1 == '0);
          cnt_d   = '0;
          state_d = ST_CALC;
        end
      end
      ST_CALC: begin
        dvd_d  = {dvd_q[DIVIDEND_W-2:0], step_qbit};
        prem_d = step_prem;
        cnt_d  = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_STEP) begin
          cnt_d   = '0;
`ifdef DOWNSAMPLE_DIV_ROUND_EN
          state_d = ST_ROUND;
`else
          state_d = ST_DONE;
`endif
        end
      end
`ifdef DOWNSAMPLE_DIV_ROUND_EN
      ST_ROUND: begin
        // Remainder becomes r - d so that quot * d + rem still equals the dividend.
        if (round_up) begin
          dvd_d  = dvd_q + DIVIDEND_W'(1);
          prem_d = prem_q - {1'b0, dvsr_q};
        end
        state_d = ST_DONE;
      end
`endif
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Result formed from the values about to be registered, so it lands exactly on entry to DONE.
  always_comb begin
    if (dz_q) begin
      quot_res = neg_q ? {1'b1, {(DIVIDEND_W-1){1'b0}}} : {1'b0, {(DIVIDEND_W-1){1'b1}}};
      rem_res  = '0;
    end else begin
      quot_res = neg_q ? -$signed(dvd_d) : $signed(dvd_d);
      rem_res  = neg_q ? -$signed(prem_d) : $signed(prem_d);
    end
  end

  // Control and result registers
  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      done_q     <= 1'b0;
      idle_q     <= 1'b1;
      quot_q     <= '0;
      rem_q      <= '0;
      div_zero_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= (state_d == ST_DONE);
      idle_q  <= (state_d == ST_IDLE);
      if (state_d == ST_DONE) begin
        quot_q     <= quot_res;
        rem_q      <= rem_res;
        div_zero_q <= dz_q;
      end
    end
  end

  // Datapath registers
  always_ff @(posedge ap_clk) begin
    dvd_q  <= dvd_d;
    prem_q <= prem_d;
    dvsr_q <= dvsr_d;
    neg_q  <= neg_d;
    dz_q   <= dz_d;
  end

  assign bus.ap_ready = ap_rst_n & bus.ap_start & (state_q == ST_IDLE);
  assign bus.ap_idle  = idle_q;
  assign bus.ap_done  = done_q;
  assign bus.quot     = quot_q;
  assign bus.rem      = rem_q;
  assign bus.div_zero = div_zero_q;

endmodule
